// File: rtl/offset_cmd_scheduler.sv
// offset_cmd_scheduler
// Turns four raw direction buttons {Right, Left, Down, Up} into clean,
// frame-synchronised one-hot OffsetFlag pulses. Each button has a 2-flop
// synchroniser, a debouncer, press detection and a one-deep pending latch.
// Opposing presses on one axis cancel. A round-robin arbiter grants one
// command per vertical blank.
// Optional feature: define OFFSET_AUTO_REPEAT_EN to re-issue a held
// direction every REPEAT_FRAMES vblank rising edges.
module offset_cmd_scheduler #(
    parameter int DEB_CYCLES    = 250000,
    parameter int PULSE_LEN     = 4,
    parameter int REPEAT_FRAMES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btnIn,
    input  logic       vblank,
    output logic [3:0] OffsetFlag,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int            DW         = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam int            PW         = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

    // Reject configurations that cannot produce a meaningful pulse or repeat.
    if (DEB_CYCLES < 1) begin : g_chk_deb
        $error("DEB_CYCLES must be >= 1");
    end
    if (PULSE_LEN < 1) begin : g_chk_pulse
        $error("PULSE_LEN must be >= 1");
    end
    if (REPEAT_FRAMES < 1) begin : g_chk_repeat
        $error("REPEAT_FRAMES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VBLANK,
        ISSUE,
        HOLD,
        WAIT_ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          stable_q, stable_d;
    logic [3:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]          pending_q, pending_d;
    logic [3:0]          flag_q, flag_d;
    logic [PW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;

    logic [3:0]          press_rise;
    logic [3:0]          repeat_req;
    logic [3:0]          grant_oh;
    logic [1:0]          grant_idx;
    logic [1:0]          scan_idx;
    logic                grant_found;
    logic                issue_go;
    logic                pulse_end;

    // Two-flop synchroniser for the asynchronous button pins.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btnIn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES differing samples.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i]  = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    // A press is the 0->1 transition of the debounced level; release is ignored.
    assign press_rise = stable_d & ~stable_q;

`ifdef OFFSET_AUTO_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);

    logic               vblank_q;
    logic               vblank_rise;
    logic [3:0][RW-1:0] rep_cnt_q, rep_cnt_d;

    assign vblank_rise = vblank & ~vblank_q;

    // Count frames while a direction is held; re-request on wrap.
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        repeat_req = '0;
        for (int i = 0; i < 4; i++) begin
            if (!stable_q[i]) begin
                rep_cnt_d[i] = '0;
            end else if (vblank_rise) begin
                if (rep_cnt_q[i] == REP_LAST) begin
                    repeat_req[i] = 1'b1;
                    rep_cnt_d[i]  = '0;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
                end
            end
        end
    end

    // Repeat counters and vblank edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_q  <= 1'b0;
            rep_cnt_q <= '0;
        end else begin
            vblank_q  <= vblank;
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    assign repeat_req = '0;
`endif

    // Round-robin search of pending requests starting at rr_ptr_q.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = rr_ptr_q;
        grant_found = 1'b0;
        scan_idx    = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!grant_found && pending_q[scan_idx]) begin
                grant_found        = 1'b1;
                grant_idx          = scan_idx;
                grant_oh[scan_idx] = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q != '0) state_d = WAIT_VBLANK;
            end
            WAIT_VBLANK: begin
                if (pending_q == '0) state_d = IDLE;
                else if (vblank)     state_d = ISSUE;
            end
            ISSUE, HOLD: begin
                if (pulse_cnt_q == '0) state_d = WAIT_ACTIVE;
                else                   state_d = HOLD;
            end
            WAIT_ACTIVE: begin
                if (!vblank) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grant strobe, pulse termination and busy.
    always_comb begin
        issue_go  = (state_q == WAIT_VBLANK) && vblank && (pending_q != '0);
        pulse_end = ((state_q == ISSUE) || (state_q == HOLD)) && (pulse_cnt_q == '0);
        busy      = (state_q == ISSUE) || (state_q == HOLD) || (state_q == WAIT_ACTIVE);
    end

    // Datapath next state: pending latch with axis cancel, flag, counters.
    // The flag is loaded on the edge that enters ISSUE so that the ISSUE
    // cycle is the first of the PULSE_LEN high cycles.
    always_comb begin
        pending_d = (pending_q & ~(issue_go ? grant_oh : 4'b0000)) | press_rise | repeat_req;
        if (pending_d[0] && pending_d[1]) pending_d[1:0] = 2'b00;
        if (pending_d[2] && pending_d[3]) pending_d[3:2] = 2'b00;

        flag_d      = flag_q;
        pulse_cnt_d = pulse_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (issue_go) begin
            flag_d      = grant_oh;
            pulse_cnt_d = PULSE_LAST;
            rr_ptr_d    = grant_idx + 2'd1;
        end else if (pulse_end) begin
            flag_d = '0;
        end else if ((state_q == ISSUE) || (state_q == HOLD)) begin
            pulse_cnt_d = pulse_cnt_q - PW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q    <= '0;
            deb_cnt_q   <= '0;
            pending_q   <= '0;
            flag_q      <= '0;
            pulse_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            stable_q    <= stable_d;
            deb_cnt_q   <= deb_cnt_d;
            pending_q   <= pending_d;
            flag_q      <= flag_d;
            pulse_cnt_q <= pulse_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign OffsetFlag = flag_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_offset_cmd_scheduler.sv
// Directed bench for offset_cmd_scheduler with a pulse scoreboard.
// Expected pulse values are queued when a command is set up and popped by
// the monitor when the DUT starts a pulse.
module tb_offset_cmd_scheduler;

    localparam int DEB   = 8;
    localparam int PLEN  = 4;
    localparam int RFRM  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btnIn = 4'b0000;
    logic       vblank = 1'b0;
    logic [3:0] OffsetFlag;
    logic [3:0] pending;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int base;

    logic [3:0] exp_q[$];

    offset_cmd_scheduler #(
        .DEB_CYCLES   (DEB),
        .PULSE_LEN    (PLEN),
        .REPEAT_FRAMES(RFRM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btnIn     (btnIn),
        .vblank    (vblank),
        .OffsetFlag(OffsetFlag),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: active region then a vblank interval long enough for a pulse.
    task automatic frame();
        vblank = 1'b0;
        tick(20);
        vblank = 1'b1;
        tick(12);
        vblank = 1'b0;
    endtask

    // Press a set of buttons, let them debounce, then release them.
    task automatic tap(input logic [3:0] mask);
        btnIn = btnIn | mask;
        tick(DEB + 4);
        btnIn = btnIn & ~mask;
        tick(DEB + 4);
    endtask

    // Pulse monitor: pops the scoreboard at each pulse start, checks the
    // value stays put and the length equals PLEN.
    logic       in_pulse = 1'b0;
    int         plen = 0;
    logic [3:0] cur = 4'b0000;

    always @(negedge clk) begin
        if (reset) begin
            in_pulse = 1'b0;
            plen     = 0;
        end else if (!in_pulse && OffsetFlag != 4'b0000) begin
            in_pulse = 1'b1;
            plen     = 1;
            cur      = OffsetFlag;
            pulses++;
            if (exp_q.size() == 0) check("unexpected_pulse", OffsetFlag, 4'b0000);
            else                   check("pulse_value", OffsetFlag, exp_q.pop_front());
        end else if (in_pulse && OffsetFlag != 4'b0000) begin
            plen++;
            check("pulse_hold", OffsetFlag, cur);
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("pulse_len", plen, PLEN);
        end
    end

    initial begin
        // Reset state.
        tick(3);
        check("rst_flag", OffsetFlag, 4'b0000);
        check("rst_pending", pending, 4'b0000);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(3);

        // Test 1: clean Up press, latency 2 + DEB cycles, then one pulse.
        btnIn = 4'b0001;
        tick(DEB + 1);
        check("t1_pend_early", pending, 4'b0000);
        tick(1);
        check("t1_pend_set", pending, 4'b0001);
        btnIn = 4'b0000;
        tick(DEB + 4);
        check("t1_idle_busy", busy, 1'b0);
        exp_q.push_back(4'b0001);
        base = pulses;
        vblank = 1'b1;
        tick(1);
        check("t1_flag_c1", OffsetFlag, 4'b0001);
        check("t1_busy", busy, 1'b1);
        check("t1_pend_clr", pending, 4'b0000);
        for (int i = 0; i < PLEN - 1; i++) begin
            tick(1);
            check("t1_flag_hold", OffsetFlag, 4'b0001);
        end
        tick(1);
        check("t1_flag_off", OffsetFlag, 4'b0000);
        check("t1_pend_after", pending, 4'b0000);
        tick(4);
        vblank = 1'b0;
        tick(3);
        check("t1_busy_end", busy, 1'b0);
        check("t1_pulses", pulses - base, 1);

        // Test 2: Right bouncing every 3 cycles, ending held high.
        base = pulses;
        for (int t = 0; t < 7; t++) begin
            btnIn[3] = ~btnIn[3];
            tick(3);
        end
        check("t2_no_bounce_pend", pending, 4'b0000);
        tick(DEB + 2 - 3 - 1);
        check("t2_pend_early", pending, 4'b0000);
        tick(1);
        check("t2_pend_set", pending, 4'b1000);
        btnIn = 4'b0000;
        tick(DEB + 4);
        exp_q.push_back(4'b1000);
        frame();
        tick(5);
        check("t2_pulses", pulses - base, 1);
        check("t2_q_empty", exp_q.size(), 0);

        // Test 3: Left then Right inside one debounce window cancel out.
        base = pulses;
        btnIn = 4'b0100;
        tick(3);
        btnIn = 4'b1100;
        tick(DEB + 2 - 3);
        check("t3_left_pend", pending, 4'b0100);
        tick(3);
        check("t3_cancel", pending, 4'b0000);
        btnIn = 4'b0000;
        tick(DEB + 4);
        for (int f = 0; f < 3; f++) frame();
        tick(5);
        check("t3_no_pulse", pulses - base, 0);

        // Test 4: Up and Left pending together, served one per frame.
        base = pulses;
        tap(4'b0001);
        tap(4'b0100);
        check("t4_both_pend", pending, 4'b0101);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        frame();
        tick(2);
        check("t4_frame_n", pulses - base, 1);
        check("t4_pend_mid", pending, 4'b0100);
        frame();
        tick(2);
        check("t4_frame_n1", pulses - base, 2);
        check("t4_pend_end", pending, 4'b0000);
        check("t4_rr_ptr", dut.rr_ptr_q, 2'd3);
        check("t4_q_empty", exp_q.size(), 0);

        // Test 5: reset on the second cycle of a pulse.
        tap(4'b0001);
        check("t5_pend", pending, 4'b0001);
        exp_q.push_back(4'b0001);
        base = pulses;
        vblank = 1'b1;
        tick(1);
        check("t5_flag_c1", OffsetFlag, 4'b0001);
        tick(1);
        check("t5_flag_c2", OffsetFlag, 4'b0001);
        reset = 1'b1;
        tick(1);
        check("t5_rst_flag", OffsetFlag, 4'b0000);
        check("t5_rst_pend", pending, 4'b0000);
        check("t5_rst_busy", busy, 1'b0);
        reset = 1'b0;
        vblank = 1'b0;
        tick(2);
        frame();
        frame();
        tick(5);
        check("t5_no_resume", pulses - base, 1);
        check("t5_q_empty", exp_q.size(), 0);

        // Test 6: Down held for 10 frames.
        base = pulses;
        btnIn = 4'b0010;
        tick(DEB + 4);
        check("t6_pend", pending, 4'b0010);
`ifdef OFFSET_AUTO_REPEAT_EN
        for (int k = 0; k < 4; k++) exp_q.push_back(4'b0010);
`else
        exp_q.push_back(4'b0010);
`endif
        for (int f = 0; f < 10; f++) frame();
        btnIn = 4'b0000;
        tick(DEB + 10);
`ifdef OFFSET_AUTO_REPEAT_EN
        check("t6_pulses", pulses - base, 4);
`else
        check("t6_pulses", pulses - base, 1);
`endif
        check("t6_q_empty", exp_q.size(), 0);
        check("t6_pend_end", pending, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/offset_cmd_scheduler.md
Name: offset_cmd_scheduler

Overview:
- Turns the four raw direction buttons into clean, frame-synchronised offset commands for the drawable-region offset logic.
- Per button: synchroniser, debounce, press detect, pending latch. Opposing presses on the same axis cancel.
- Round-robin arbiter grants one command per vertical blank. The grant drives a one-hot OffsetFlag pulse of fixed length, so the region never moves mid-frame.
- Sits between the board button pins and the offset handler. Clocked by the pixel clock.

Parameters:
- DEB_CYCLES, 250000, cycles a synchronised button level must stay stable before it is accepted (10 ms at 25 MHz); counter width = clog2(DEB_CYCLES+1).
- PULSE_LEN, 4, cycles OffsetFlag is held high per command (min 1).
- REPEAT_FRAMES, 15, frames between auto-repeat commands while a button is held (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- btnIn  in  4  raw asynchronous buttons {Right, Left, Down, Up}, active-high
- vblank  in  1  high during vertical blanking, synchronous to clk
- OffsetFlag  out  4  one-hot move pulse {Right, Left, Down, Up} to offset handler
- pending  out  4  latched, not-yet-issued requests, same bit order
- busy  out  1  high while a command is being issued (states ISSUE, HOLD, WAIT_ACTIVE)

Behaviour:
- Reset (synchronous, active-high, sampled on the clk rising edge):
  - OffsetFlag=0, pending=0, busy=0, state=IDLE, rrPtr=0 (Up has highest priority first).
  - Debounce counters=0, stable levels=0, synchroniser flops=0, repeat counters=0.
  - Reset asserted mid-pulse drops OffsetFlag to 0 on the next edge; no partial command is recorded.
- Synchroniser: 2 flops per bit. A btnIn change becomes visible to the debouncer 2 cycles later.
- Debounce, per bit:
  - While the synchronised level differs from the stable level, the counter increments; any return to the stable level clears the counter.
  - When the counter reaches DEB_CYCLES-1, the stable level takes the new value and the counter clears.
  - Total press latency = 2 + DEB_CYCLES cycles.
- Press detect: a 0->1 transition of the stable level sets the matching pending bit. Release does nothing.
- Axis cancel:
  - If Up and Down pending are both set after an update, both clear in the same cycle. Left/Right likewise.
  - A pending bit being granted in that same cycle is not affected by the cancel.
- FSM:
  - IDLE: if pending!=0 -> WAIT_VBLANK.
  - WAIT_VBLANK: wait for vblank=1. If pending becomes 0 (via cancel), return to IDLE.
  - ISSUE (1 cycle):
    - Grant = first set pending bit searching from rrPtr upward, modulo 4.
    - Clear that pending bit; set OffsetFlag to the grant one-hot.
    - rrPtr = grant index + 1, mod 4.
  - HOLD: OffsetFlag held until it has been high for PULSE_LEN cycles total (ISSUE cycle included), then OffsetFlag=0 -> WAIT_ACTIVE.
  - WAIT_ACTIVE: wait for vblank=0, then -> IDLE. This guarantees at most one command per frame.
- OffsetFlag is registered. At most one bit is ever high, and it only changes on clk edges.
- If vblank falls during HOLD, the pulse still completes full length.
- New presses during busy set pending bits normally and are served in later frames.
- A press on a bit that is already pending is absorbed (no queue depth beyond 1 per direction).

Optional Feature:
- Macro: OFFSET_AUTO_REPEAT_EN.
- Defined:
  - Each direction has a frame counter, counting vblank rising edges while its stable level=1.
  - On reaching REPEAT_FRAMES, that pending bit is set again and the counter clears.
  - The counter clears on release and on reset.
  - Axis cancel applies to repeat-generated requests as well.
- Undefined: no repeat logic; exactly one command per press.

Test Plan:
- Run with DEB_CYCLES=8 and PULSE_LEN=4.
  - Exception: test 2 uses DEB_CYCLES=8 only; test 6 uses the stated REPEAT_FRAMES=3.
- 1. Up pressed clean, vblank rises later:
  - Required: pending=0001 at cycle 10 after press.
  - Required: OffsetFlag=0001 for exactly 4 cycles starting the cycle after WAIT_VBLANK sees vblank=1; pending=0000 after.
- 2. Right bouncing (toggle every 3 cycles for 20 cycles, then held):
  - Required: exactly one pending[3] set, 10 cycles after the last toggle; one OffsetFlag=1000 pulse.
- 3. Left and Right pressed within the same debounce window, both pending before vblank:
  - Required: pending clears to 0000 and no OffsetFlag pulse in the next 3 frames.
- 4. Up, Left, Right? No: Up, Down excluded. Press Up then Left, both pending before one vblank:
  - Required: frame N issues 0001, frame N+1 issues 0100, one pulse per frame, rrPtr=3 after.
- 5. Reset asserted on the 2nd cycle of an OffsetFlag pulse:
  - Required: OffsetFlag=0000, pending=0000, busy=0 on the next edge; no pulse resumes after reset is released.
- 6. With OFFSET_AUTO_REPEAT_EN and REPEAT_FRAMES=3, Down held for 10 frames:
  - Required: initial pulse, then repeat pulses at frames 3, 6, 9 (4 pulses, all 0010).
  - Without the macro: exactly 1 pulse.
